segasys1_hiscore_xfer: RTL and testbench

Initiator for the hiscore/NVRAM access port of the SEGA System 1/2 core. It drives HSAD, HSDI and HSWE, reads HSDO, and holds PAUSE_N low while it moves a contiguous RAM region between the core and a host byte stream. Save mode reads core RAM out to the host; load mode writes host bytes into core RAM. It sits beside the core top level, with the host and OSD side on its other end.

---
 rtl/segasys1_hs_pkg.sv | 32 +++
 rtl/segasys1_hs_rdpipe.sv | 35 +++
 rtl/segasys1_hiscore_xfer.sv | 252 +++++++++++++++++++++++++
 tb/tb_segasys1_hiscore_xfer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_hs_pkg.sv
// Shared types and defaults for the SEGA System 1/2 hiscore/NVRAM transfer initiator.
package segasys1_hs_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SETTLE  = 4'd1,
    S_RD_WAIT = 4'd2,
    S_RD_PUSH = 4'd3,
    S_LD_WAIT = 4'd4,
    S_LD_WR   = 4'd5,
    S_CK_PUSH = 4'd6,
    S_CK_WAIT = 4'd7,
    S_FIN     = 4'd8
  } hs_state_e;

  // HSAD[15:12] value that routes an access to main RAM rather than video RAM
  localparam logic [3:0]  HS_MAIN_RAM_NIB     = 4'hC;

  localparam logic [15:0] HS_DEF_START_ADDR   = 16'hC000;
  localparam logic [15:0] HS_DEF_LENGTH       = 16'd256;
  localparam int          HS_DEF_RD_LAT       = 2;
  localparam int          HS_DEF_PAUSE_SETTLE = 8;

  function automatic logic [7:0] hs_sum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  function automatic logic [7:0] hs_sum_neg(input logic [7:0] sum);
    return 8'd0 - sum;
  endfunction

endpackage

// File: rtl/segasys1_hs_rdpipe.sv
// Read-latency counter: raises cap_stb in the RD_LAT-th consecutive cycle that en is held.
module segasys1_hs_rdpipe
  import segasys1_hs_pkg::*;
#(
  parameter int RD_LAT = HS_DEF_RD_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic cap_stb
);

  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  logic [2:0] cnt_q, cnt_d;

  assign cap_stb = en && (cnt_q == LAST_CNT);

  always_comb begin
    if (en && !cap_stb) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/segasys1_hiscore_xfer.sv
// Hiscore/NVRAM transfer initiator: pauses the core and streams a RAM region out (save) or in (load).
// Optional trailing checksum byte enabled by defining HISCORE_CHECKSUM_EN.
module segasys1_hiscore_xfer
  import segasys1_hs_pkg::*;
#(
  parameter logic [15:0] START_ADDR   = HS_DEF_START_ADDR,
  parameter logic [15:0] LENGTH       = HS_DEF_LENGTH,
  parameter int          RD_LAT       = HS_DEF_RD_LAT,
  parameter int          PAUSE_SETTLE = HS_DEF_PAUSE_SETTLE
) (
  input  logic        clk40M,
  input  logic        reset,
  input  logic        start_save,
  input  logic        start_load,
  output logic [7:0]  sv_data,
  output logic        sv_valid,
  input  logic        sv_ready,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        PAUSE_N,
  output logic [15:0] HSAD,
  output logic [7:0]  HSDI,
  input  logic [7:0]  HSDO,
  output logic        HSWE
);

`ifdef HISCORE_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  localparam logic [15:0] LAST_IDX = LENGTH - 16'd1;

  hs_state_e   state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  settle_q, settle_d;
  logic        save_q, save_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  sv_data_q, sv_data_d;
  logic        sv_valid_q, sv_valid_d;
  logic        ld_ready_q, ld_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pause_n_q, pause_n_d;
  logic [15:0] hsad_q, hsad_d;
  logic [7:0]  hsdi_q, hsdi_d;
  logic        hswe_q, hswe_d;

  logic        cap_stb_s;
  logic        last_s;
  logic        settle_done_s;
  logic        fin_s;

  segasys1_hs_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
    .clk     (clk40M),
    .reset   (reset),
    .en      (state_q == S_RD_WAIT),
    .cap_stb (cap_stb_s)
  );

  assign last_s        = (idx_q == LAST_IDX);
  assign settle_done_s = (int'(settle_q) + 1 >= PAUSE_SETTLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    save_d     = save_q;
    sum_d      = sum_q;
    sv_data_d  = sv_data_q;
    sv_valid_d = sv_valid_q;
    ld_ready_d = ld_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    pause_n_d  = pause_n_q;
    hsad_d     = hsad_q;
    hsdi_d     = hsdi_q;
    hswe_d     = 1'b0;
    fin_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_save || start_load) begin
          state_d   = S_SETTLE;
          save_d    = start_save;
          pause_n_d = 1'b0;
          busy_d    = 1'b1;
          idx_d     = 16'd0;
          settle_d  = 8'd0;
          sum_d     = 8'd0;
          err_d     = 1'b0;
          hsad_d    = START_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        hsad_d = START_ADDR;
        if (!settle_done_s) begin
          settle_d = settle_q + 8'd1;
        end else if (save_q) begin
          state_d = S_RD_WAIT;
        end else begin
          state_d    = S_LD_WAIT;
          ld_ready_d = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (cap_stb_s) begin
          sv_data_d  = HSDO;
          sv_valid_d = 1'b1;
          sum_d      = hs_sum_add(sum_q, HSDO);
          state_d    = S_RD_PUSH;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_PUSH: begin
        if (!sv_ready) begin
          state_d = S_RD_PUSH;
        end else if (!last_s) begin
          sv_valid_d = 1'b0;
          idx_d      = idx_q + 16'd1;
          hsad_d     = START_ADDR + idx_q + 16'd1;
          state_d    = S_RD_WAIT;
        end else if (CK_EN) begin
          idx_d     = idx_q + 16'd1;
          sv_data_d = hs_sum_neg(sum_q);
          hsad_d    = START_ADDR;
          state_d   = S_CK_PUSH;
        end else begin
          sv_valid_d = 1'b0;
          idx_d      = idx_q + 16'd1;
          fin_s      = 1'b1;
        end
      end
      S_LD_WAIT: begin
        if (ld_valid && ld_ready_q) begin
          hsdi_d     = ld_data;
          ld_ready_d = 1'b0;
          hswe_d     = 1'b1;
          state_d    = S_LD_WR;
        end else begin
          state_d = S_LD_WAIT;
        end
      end
      S_LD_WR: begin
        idx_d = idx_q + 16'd1;
        sum_d = hs_sum_add(sum_q, hsdi_q);
        if (!last_s) begin
          ld_ready_d = 1'b1;
          hsad_d     = START_ADDR + idx_q + 16'd1;
          state_d    = S_LD_WAIT;
        end else if (CK_EN) begin
          ld_ready_d = 1'b1;
          state_d    = S_CK_WAIT;
        end else begin
          fin_s = 1'b1;
        end
      end
      S_CK_PUSH: begin
        if (sv_ready) begin
          sv_valid_d = 1'b0;
          fin_s      = 1'b1;
        end else begin
          state_d = S_CK_PUSH;
        end
      end
      S_CK_WAIT: begin
        // checksum byte is consumed without a RAM write; earlier writes stand
        if (ld_valid && ld_ready_q) begin
          ld_ready_d = 1'b0;
          err_d      = (hs_sum_add(sum_q, ld_data) != 8'd0);
          fin_s      = 1'b1;
        end else begin
          state_d = S_CK_WAIT;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fin_s) begin
      state_d   = S_FIN;
      pause_n_d = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      hsad_d    = START_ADDR;
    end else begin
      state_d = state_d;
    end
  end

  always_ff @(posedge clk40M) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 16'd0;
      settle_q   <= 8'd0;
      save_q     <= 1'b0;
      sum_q      <= 8'd0;
      sv_data_q  <= 8'd0;
      sv_valid_q <= 1'b0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pause_n_q  <= 1'b1;
      hsad_q     <= START_ADDR;
      hsdi_q     <= 8'd0;
      hswe_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      save_q     <= save_d;
      sum_q      <= sum_d;
      sv_data_q  <= sv_data_d;
      sv_valid_q <= sv_valid_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pause_n_q  <= pause_n_d;
      hsad_q     <= hsad_d;
      hsdi_q     <= hsdi_d;
      hswe_q     <= hswe_d;
    end
  end

  assign sv_data  = sv_data_q;
  assign sv_valid = sv_valid_q;
  assign ld_ready = ld_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = CK_EN ? err_q : 1'b0;
  assign PAUSE_N  = pause_n_q;
  assign HSAD     = hsad_q;
  assign HSDI     = hsdi_q;
  assign HSWE     = hswe_q;

endmodule

// File: tb/tb_segasys1_hiscore_xfer.sv
// Scoreboard bench for segasys1_hiscore_xfer: instance A in main RAM at C000, instance B wrapping at FFFE.
module tb_segasys1_hiscore_xfer;
  import segasys1_hs_pkg::*;

  localparam logic [15:0] START_A = {HS_MAIN_RAM_NIB, 12'h000};
  localparam logic [15:0] START_B = 16'hFFFE;
  localparam logic [15:0] LEN     = 16'd4;
`ifdef HISCORE_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk40M = 1'b0;
  logic reset  = 1'b1;
  always #5 clk40M = ~clk40M;

  logic        start_save_a = 1'b0, start_load_a = 1'b0;
  logic        start_save_b = 1'b0, start_load_b = 1'b0;
  logic        sv_ready = 1'b0, ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic [7:0]  sv_data_a, sv_data_b, hsdi_a, hsdi_b;
  logic [7:0]  hsdo_a = 8'd0, hsdo_b = 8'd0;
  logic        sv_valid_a, sv_valid_b, ld_ready_a, ld_ready_b, busy_a, busy_b;
  logic        done_a, done_b, err_a, err_b, pause_n_a, pause_n_b, hswe_a, hswe_b;
  logic [15:0] hsad_a, hsad_b;
  logic [7:0]  mem [0:65535];

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        chk_addr;
  } exp_t;

  exp_t q_sv_a[$];
  exp_t q_sv_b[$];
  exp_t q_wr_a[$];
  int   n_cmp = 0, n_mis = 0;
  int   done_cnt_a = 0, done_cnt_b = 0, hswe_cnt = 0;
  logic hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] held_a = 8'd0, held_b = 8'd0;

  segasys1_hiscore_xfer #(.START_ADDR(START_A), .LENGTH(LEN), .RD_LAT(2), .PAUSE_SETTLE(8)) u_dut_a (
    .clk40M(clk40M), .reset(reset), .start_save(start_save_a), .start_load(start_load_a),
    .sv_data(sv_data_a), .sv_valid(sv_valid_a), .sv_ready(sv_ready),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
    .busy(busy_a), .done(done_a), .err(err_a), .PAUSE_N(pause_n_a),
    .HSAD(hsad_a), .HSDI(hsdi_a), .HSDO(hsdo_a), .HSWE(hswe_a)
  );

  segasys1_hiscore_xfer #(.START_ADDR(START_B), .LENGTH(LEN), .RD_LAT(2), .PAUSE_SETTLE(3)) u_dut_b (
    .clk40M(clk40M), .reset(reset), .start_save(start_save_b), .start_load(start_load_b),
    .sv_data(sv_data_b), .sv_valid(sv_valid_b), .sv_ready(sv_ready),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
    .busy(busy_b), .done(done_b), .err(err_b), .PAUSE_N(pause_n_b),
    .HSAD(hsad_b), .HSDI(hsdi_b), .HSDO(hsdo_b), .HSWE(hswe_b)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Core RAM model: one registered stage gives HSDO two cycles after an HSAD change
  always @(posedge clk40M) begin
    hsdo_a <= mem[hsad_a];
    hsdo_b <= mem[hsad_b];
    if (hswe_a === 1'b1) mem[hsad_a] <= hsdi_a;
  end

  always @(negedge clk40M) begin
    exp_t e;
    if (sv_valid_a === 1'b1 && sv_ready) begin
      if (q_sv_a.size() == 0) check("sv_a_unexpected", 32'd1, 32'd0);
      else begin
        e = q_sv_a.pop_front();
        check("sv_a_data", {24'd0, sv_data_a}, {24'd0, e.data});
        if (e.chk_addr) check("sv_a_hsad", {16'd0, hsad_a}, {16'd0, e.addr});
      end
    end
    if (hold_a) begin
      check("sv_a_hold_valid", {31'd0, sv_valid_a}, 32'd1);
      check("sv_a_hold_data", {24'd0, sv_data_a}, {24'd0, held_a});
    end
    hold_a <= (sv_valid_a === 1'b1) && !sv_ready;
    held_a <= sv_data_a;
    if (hswe_a === 1'b1) begin
      hswe_cnt <= hswe_cnt + 1;
      if (q_wr_a.size() == 0) check("wr_a_unexpected", 32'd1, 32'd0);
      else begin
        e = q_wr_a.pop_front();
        check("wr_a_addr", {16'd0, hsad_a}, {16'd0, e.addr});
        check("wr_a_data", {24'd0, hsdi_a}, {24'd0, e.data});
      end
    end
    if (busy_a === 1'b1) check("pause_a_low", {31'd0, pause_n_a}, 32'd0);
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
  end

  always @(negedge clk40M) begin
    exp_t e;
    if (sv_valid_b === 1'b1 && sv_ready) begin
      if (q_sv_b.size() == 0) check("sv_b_unexpected", 32'd1, 32'd0);
      else begin
        e = q_sv_b.pop_front();
        check("sv_b_data", {24'd0, sv_data_b}, {24'd0, e.data});
        if (e.chk_addr) check("sv_b_hsad", {16'd0, hsad_b}, {16'd0, e.addr});
      end
    end
    if (hold_b) check("sv_b_hold_data", {24'd0, sv_data_b}, {24'd0, held_b});
    hold_b <= (sv_valid_b === 1'b1) && !sv_ready;
    held_b <= sv_data_b;
    if (busy_b === 1'b1) begin
      check("pause_b_low", {31'd0, pause_n_b}, 32'd0);
      check("hswe_b_zero", {31'd0, hswe_b}, 32'd0);
    end
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic step();
    @(posedge clk40M);
    #1;
  endtask

  task automatic pulse(input bit b_inst, input bit sv, input bit ld);
    if (b_inst) start_save_b = sv;
    else begin
      start_save_a = sv;
      start_load_a = ld;
    end
    step();
    start_save_a = 1'b0;
    start_load_a = 1'b0;
    start_save_b = 1'b0;
  endtask

  task automatic push_sv(input bit b_inst, input logic [15:0] addr, input logic [7:0] data, input bit chk);
    exp_t e;
    e.addr = addr; e.data = data; e.chk_addr = chk;
    if (b_inst) q_sv_b.push_back(e);
    else q_sv_a.push_back(e);
  endtask

  task automatic push_wr(input logic [15:0] addr, input logic [7:0] data);
    exp_t e;
    e.addr = addr; e.data = data; e.chk_addr = 1'b1;
    q_wr_a.push_back(e);
  endtask

  task automatic feed(input logic [7:0] b);
    bit ok = 1'b0;
    ld_valid = 1'b1;
    ld_data  = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (ld_ready_a) ok = 1'b1;
      step();
    end
    ld_valid = 1'b0;
    check("ld_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(input bit b_inst, input logic [3:0] pat);
    bit seen = 1'b0;
    int k = 0;
    while (k < 400 && !seen) begin
      if (b_inst ? done_b : done_a) seen = 1'b1;
      else begin
        sv_ready = pat[k % 4];
        step();
        k++;
      end
    end
    sv_ready = 1'b1;
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("fin_pause_n", {31'd0, b_inst ? pause_n_b : pause_n_a}, 32'd1);
      check("fin_busy", {31'd0, b_inst ? busy_b : busy_a}, 32'd0);
      step();
      check("done_one_cycle", {31'd0, b_inst ? done_b : done_a}, 32'd0);
    end
  endtask

  initial begin
    int h0;
    logic [7:0] ld_bytes [4];
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);

    repeat (3) step();
    check("rst_hsad_a", {16'd0, hsad_a}, {16'd0, START_A});
    check("rst_hsad_b", {16'd0, hsad_b}, {16'd0, START_B});
    check("rst_hsdi", {16'd0, hsdi_a, hsdi_b}, 32'd0);
    check("rst_flags_a", {24'd0, hswe_a, pause_n_a, busy_a, done_a, err_a, sv_valid_a, ld_ready_a, 1'b0}, 32'h40);
    check("rst_flags_b", {24'd0, hswe_b, pause_n_b, busy_b, done_b, err_b, sv_valid_b, ld_ready_b, 1'b0}, 32'h40);
    reset = 1'b0;
    sv_ready = 1'b1;
    step();

    // save of four incrementing bytes at C000
    for (int i = 0; i < 4; i++) push_sv(1'b0, START_A + 16'(i), 8'(i), 1'b1);
    if (CK) push_sv(1'b0, 16'd0, 8'hFA, 1'b0);
    h0 = hswe_cnt;
    pulse(1'b0, 1'b1, 1'b0);
    check("t1_pause_after_start", {30'd0, pause_n_a, busy_a}, 32'd1);
    wait_done(1'b0, 4'b1111);
    check("t1_done_cnt", done_cnt_a, 1);
    check("t1_no_hswe", hswe_cnt, h0);
    check("t1_sv_q_empty", q_sv_a.size(), 0);

    // load AA 55 0F C3
    ld_bytes = '{8'hAA, 8'h55, 8'h0F, 8'hC3};
    for (int i = 0; i < 4; i++) push_wr(START_A + 16'(i), ld_bytes[i]);
    pulse(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) feed(ld_bytes[i]);
    if (CK) feed(8'h2F);
    wait_done(1'b0, 4'b1111);
    for (int i = 0; i < 4; i++) check("t2_mem", {24'd0, mem[START_A + 16'(i)]}, {24'd0, ld_bytes[i]});
    check("t2_err", {31'd0, err_a}, 32'd0);
    check("t2_wr_q_empty", q_wr_a.size(), 0);

    // save back under a 1-0-0-1 ready pattern
    for (int i = 0; i < 4; i++) push_sv(1'b0, START_A + 16'(i), ld_bytes[i], 1'b1);
    if (CK) push_sv(1'b0, 16'd0, 8'h2F, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    wait_done(1'b0, 4'b1001);
    check("t3_sv_q_empty", q_sv_a.size(), 0);

    // address wrap FFFE FFFF 0000 0001
    push_sv(1'b1, 16'hFFFE, 8'hFE, 1'b1);
    push_sv(1'b1, 16'hFFFF, 8'hFF, 1'b1);
    push_sv(1'b1, 16'h0000, 8'h00, 1'b1);
    push_sv(1'b1, 16'h0001, 8'h01, 1'b1);
    if (CK) push_sv(1'b1, 16'd0, 8'h02, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    wait_done(1'b1, 4'b1111);
    check("t4_done_cnt", done_cnt_b, 1);
    check("t4_sv_q_empty", q_sv_b.size(), 0);

    // reset while the second byte is being written
    push_wr(START_A, 8'h11);
    push_wr(START_A + 16'd1, 8'h22);
    pulse(1'b0, 1'b0, 1'b1);
    feed(8'h11);
    feed(8'h22);
    check("t5_in_wr", {31'd0, hswe_a}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_abort", {29'd0, hswe_a, pause_n_a, busy_a}, 32'h2);
    h0 = hswe_cnt;
    repeat (6) step();
    check("t5_no_more_hswe", hswe_cnt, h0);
    check("t5_mem1", {24'd0, mem[START_A + 16'd1]}, 32'h22);
    check("t5_mem2", {24'd0, mem[START_A + 16'd2]}, 32'h0F);

    // simultaneous starts pick save; starts during busy are dropped
    push_sv(1'b0, START_A, 8'h11, 1'b1);
    push_sv(1'b0, START_A + 16'd1, 8'h22, 1'b1);
    push_sv(1'b0, START_A + 16'd2, 8'h0F, 1'b1);
    push_sv(1'b0, START_A + 16'd3, 8'hC3, 1'b1);
    if (CK) push_sv(1'b0, 16'd0, 8'hFB, 1'b0);
    h0 = done_cnt_a;
    pulse(1'b0, 1'b1, 1'b1);
    repeat (12) step();
    pulse(1'b0, 1'b1, 1'b1);
    wait_done(1'b0, 4'b1111);
    repeat (20) step();
    check("t6_one_done", done_cnt_a, h0 + 1);
    check("t6_still_idle", {31'd0, busy_a}, 32'd0);
    check("t6_sv_q_empty", q_sv_a.size(), 0);
    check("t6_no_writes", q_wr_a.size(), 0);

    if (CK) begin
      // bad trailing checksum flags err until the next start
      ld_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 4; i++) push_wr(START_A + 16'(i), ld_bytes[i]);
      pulse(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) feed(ld_bytes[i]);
      feed(8'hF5);
      wait_done(1'b0, 4'b1111);
      repeat (3) step();
      check("t7_err_set", {31'd0, err_a}, 32'd1);
      for (int i = 0; i < 4; i++) push_sv(1'b0, START_A + 16'(i), ld_bytes[i], 1'b1);
      push_sv(1'b0, 16'd0, 8'hF6, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      check("t7_err_cleared", {31'd0, err_a}, 32'd0);
      wait_done(1'b0, 4'b1111);
      check("t7_sv_q_empty", q_sv_a.size(), 0);
    end else begin
      check("err_tied_low", {30'd0, err_a, err_b}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
